// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : shared RV64 datapath widths, reset PC and fetch entry type
// Revision : 1.0
// ============================================================================
package core_pkg;

  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instruction;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Wraps modulo 2^64 by construction.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] addr);
    return addr + XLEN'(INST_BYTES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// instruction_fetch_if : imem request/response, redirect and decode handshakes
// Revision : 1.0
// ============================================================================
interface instruction_fetch_if;
  import core_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] instruction;
  logic [XLEN-1:0] pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, instruction, pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, instruction, pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : synchronous DEPTH-entry FIFO of {pc, instruction} with flush
// Revision : 1.0
// ============================================================================
module fetch_fifo
  import core_pkg::*;
#(
  parameter int           DEPTH       = 2,
  parameter fetch_entry_t RESET_ENTRY = '0,
  localparam int          PTR_W       = $clog2(DEPTH),
  localparam int          CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    push_en  = push_i && !flush_i;
    pop_en   = pop_i && !flush_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // Storage is reset so the head reads RESET_ENTRY out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_ENTRY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// instruction_fetch : RV64 fetch PC, credit-limited imem requests, response
//                     FIFO and single-cycle redirect flush
// Revision : 1.0
// ============================================================================
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  localparam int           CNT_W       = $clog2(DEPTH + 1);
  localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, instruction: '0};

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             inst_valid;
  logic             push;
  logic             pop;
  logic             req_valid;
  logic             req_fire;
  logic [CNT_W:0]   inflight;

  fetch_fifo #(
    .DEPTH       (DEPTH),
    .RESET_ENTRY (RESET_ENTRY)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (bus.redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  // A slot freed by this cycle's pop is reusable immediately, which is what
  // sustains one instruction per cycle with DEPTH=2 and 1-cycle memory.
  always_comb begin
    inst_valid = !fifo_empty && !bus.redirect_valid;
    pop        = inst_valid && bus.inst_ready;
    inflight   = {1'b0, fifo_count} + {1'b0, outstanding_q} - (CNT_W+1)'(pop);
    req_valid  = !reset && !bus.redirect_valid && (inflight < (CNT_W+1)'(DEPTH));
    req_fire   = req_valid && bus.imem_req_ready;
    push       = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_q == '0);
    push_entry = '{pc: rsp_pc_q, instruction: bus.imem_rsp_data};
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
    if (bus.redirect_valid) begin
      // Everything still owed after this cycle belongs to the wrong path.
      fetch_pc_d = align_pc(bus.redirect_pc);
      rsp_pc_d   = align_pc(bus.redirect_pc);
      drop_cnt_d = outstanding_q - CNT_W'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = next_pc(fetch_pc_q);
      if (push)     rsp_pc_d   = next_pc(rsp_pc_q);
      if (bus.imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = inst_valid;
  assign bus.instruction    = fifo_head.instruction;
  assign bus.pc             = fifo_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch : directed self-checking bench for instruction_fetch
// Revision : 1.0
// ============================================================================
module tb_instruction_fetch;
  import core_pkg::*;

  logic        clk;
  logic        rst_a, rst_b, sel;
  logic        req_ready, rsp_valid, redirect_valid, inst_ready;
  logic [31:0] rsp_data;
  logic [63:0] redirect_pc;

  logic        o_req_valid, o_inst_valid;
  logic [63:0] o_req_addr, o_pc;
  logic [31:0] o_ins;

  logic        s_req_v, s_inst_v;
  logic [63:0] s_req_addr, s_pc;
  logic [31:0] s_ins;

  logic [63:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] got_pc[$];
  logic [31:0] got_ins[$];
  int          lat, ncyc, n_req, n_pop;
  int          n_chk, n_pass;

  instruction_fetch_if if_a ();
  instruction_fetch_if if_b ();

  instruction_fetch #(.RESET_PC(64'h0), .DEPTH(2)) dut_a (
    .clk (clk), .reset (rst_a), .bus (if_a)
  );
  instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .DEPTH(2)) dut_b (
    .clk (clk), .reset (rst_b), .bus (if_b)
  );

  assign if_a.imem_req_ready = req_ready;
  assign if_a.imem_rsp_valid = rsp_valid;
  assign if_a.imem_rsp_data  = rsp_data;
  assign if_a.redirect_valid = redirect_valid;
  assign if_a.redirect_pc    = redirect_pc;
  assign if_a.inst_ready     = inst_ready;
  assign if_b.imem_req_ready = req_ready;
  assign if_b.imem_rsp_valid = rsp_valid;
  assign if_b.imem_rsp_data  = rsp_data;
  assign if_b.redirect_valid = redirect_valid;
  assign if_b.redirect_pc    = redirect_pc;
  assign if_b.inst_ready     = inst_ready;

  assign o_req_valid  = sel ? if_b.imem_req_valid : if_a.imem_req_valid;
  assign o_req_addr   = sel ? if_b.imem_req_addr  : if_a.imem_req_addr;
  assign o_inst_valid = sel ? if_b.inst_valid     : if_a.inst_valid;
  assign o_pc         = sel ? if_b.pc             : if_a.pc;
  assign o_ins        = sel ? if_b.instruction    : if_a.instruction;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Samples mid-cycle, then advances one clock and presents memory responses.
  task automatic cyc();
    @(negedge clk);
    s_req_v    = o_req_valid;
    s_req_addr = o_req_addr;
    s_inst_v   = o_inst_valid;
    s_pc       = o_pc;
    s_ins      = o_ins;
    if (o_req_valid && req_ready) begin
      mq_addr.push_back(o_req_addr);
      mq_due.push_back(ncyc + lat);
      n_req++;
    end
    if (o_inst_valid && inst_ready) begin
      got_pc.push_back(o_pc);
      got_ins.push_back(o_ins);
      n_pop++;
    end
    @(posedge clk);
    #1;
    ncyc++;
    if (sel ? rst_b : rst_a) begin
      mq_addr.delete();
      mq_due.delete();
    end
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (mq_due.size() != 0 && mq_due[0] == ncyc) begin
      rsp_valid = 1'b1;
      rsp_data  = word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
  endtask

  task automatic check_next(input string tag, input logic [63:0] exp);
    logic [63:0] p;
    logic [31:0] w;
    check({tag, "_avail"}, 64'(got_pc.size() != 0), 64'd1);
    if (got_pc.size() != 0) begin
      p = got_pc.pop_front();
      w = got_ins.pop_front();
      check({tag, "_pc"}, p, exp);
      check({tag, "_ins"}, 64'(w), 64'(word(exp)));
    end
  endtask

  task automatic do_reset(input logic which, input logic [63:0] rpc);
    sel = which; rst_a = 1'b1; rst_b = 1'b1;
    redirect_valid = 1'b0; inst_ready = 1'b1; req_ready = 1'b1;
    repeat (2) cyc();
    check("rst_req_valid", 64'(s_req_v), 64'd0);
    check("rst_req_addr", s_req_addr, rpc);
    check("rst_inst_valid", 64'(s_inst_v), 64'd0);
    check("rst_instruction", 64'(s_ins), 64'd0);
    check("rst_pc", s_pc, rpc);
    if (which) rst_b = 1'b0; else rst_a = 1'b0;
    got_pc.delete(); got_ins.delete();
    n_req = 0; n_pop = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; ncyc = 0; n_req = 0; n_pop = 0; lat = 1;
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Streaming from reset with 1-cycle memory
    do_reset(1'b0, 64'h0);
    cyc();
    check("t1_req_v_c0", 64'(s_req_v), 64'd1);
    check("t1_req_addr_c0", s_req_addr, 64'h0);
    check("t1_inst_v_c0", 64'(s_inst_v), 64'd0);
    cyc();
    check("t1_req_addr_c1", s_req_addr, 64'h4);
    check("t1_inst_v_c1", 64'(s_inst_v), 64'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("t1_inst_v", 64'(s_inst_v), 64'd1);
      check("t1_pc", s_pc, 64'(4 * k));
      check("t1_ins", 64'(s_ins), 64'(word(64'(4 * k))));
    end

    // Downstream stall: buffer fills to DEPTH, requests stop, head holds
    inst_ready = 1'b0;
    repeat (5) cyc();
    check("t2_req_v_stall", 64'(s_req_v), 64'd0);
    check("t2_inst_v_stall", 64'(s_inst_v), 64'd1);
    check("t2_pc_stall", s_pc, 64'd24);
    check("t2_buffered", 64'(n_req - n_pop), 64'd2);
    inst_ready = 1'b1;
    got_pc.delete(); got_ins.delete();
    repeat (8) cyc();
    check("t2_count", 64'(got_pc.size()), 64'd8);
    for (int k = 0; k < 8; k++) check_next("t2_seq", 64'(24 + 4 * k));

    // Latency 3, two stale responses in flight at redirect
    lat = 3;
    do_reset(1'b0, 64'h0);
    repeat (2) cyc();
    redirect_valid = 1'b1; redirect_pc = 64'h1000;
    cyc();
    check("t3_req_v_redir", 64'(s_req_v), 64'd0);
    check("t3_inst_v_redir", 64'(s_inst_v), 64'd0);
    redirect_valid = 1'b0;
    repeat (8) cyc();
    check("t3_count", 64'(got_pc.size()), 64'd2);
    check_next("t3_seq0", 64'h1000);
    check_next("t3_seq1", 64'h1004);

    // Redirect coinciding with a response, misaligned target
    lat = 1;
    do_reset(1'b0, 64'h0);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 64'h1002;
    cyc();
    check("t4_req_v_redir", 64'(s_req_v), 64'd0);
    check("t4_inst_v_redir", 64'(s_inst_v), 64'd0);
    redirect_valid = 1'b0;
    cyc();
    check("t4_req_v_next", 64'(s_req_v), 64'd1);
    check("t4_req_addr_next", s_req_addr, 64'h1000);
    cyc();
    check("t4_inst_v_early", 64'(s_inst_v), 64'd0);
    cyc();
    check("t4_inst_v_first", 64'(s_inst_v), 64'd1);
    cyc();
    check_next("t4_seq0", 64'h1000);
    check_next("t4_seq1", 64'h1004);

    // Back-to-back redirects: last one wins
    repeat (2) cyc();
    got_pc.delete(); got_ins.delete();
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    cyc();
    redirect_pc = 64'h300;
    cyc();
    redirect_valid = 1'b0;
    repeat (5) cyc();
    check("t5_count", 64'(got_pc.size()), 64'd3);
    check_next("t5_seq0", 64'h300);
    check_next("t5_seq1", 64'h304);
    check_next("t5_seq2", 64'h308);

    // PC wrap from a high reset PC
    do_reset(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (6) cyc();
    check("t6_count", 64'(got_pc.size()), 64'd4);
    check_next("t6_seq0", 64'hFFFF_FFFF_FFFF_FFF8);
    check_next("t6_seq1", 64'hFFFF_FFFF_FFFF_FFFC);
    check_next("t6_seq2", 64'h0);
    check_next("t6_seq3", 64'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
